// File: rtl/traffic_controller_adaptive.sv
// rtl/traffic_controller_adaptive.sv - adaptive four-way intersection controller with left-turn skip and emergency preempt
module traffic_controller_adaptive #(
  parameter int GREEN_FWD  = 8,
  parameter int GREEN_LEFT = 4,
  parameter int YELLOW     = 2,
  parameter int ALL_RED    = 1,
  parameter int TMR_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] left_req,
  input  logic       emerg_req,
  input  logic       emerg_axis,
  output logic [1:0] N_forward,
  output logic [1:0] N_left,
  output logic [1:0] S_forward,
  output logic [1:0] S_left,
  output logic [1:0] E_forward,
  output logic [1:0] E_left,
  output logic [1:0] W_forward,
  output logic [1:0] W_left,
  output logic [2:0] phase,
  output logic       emerg_active,
  output logic [3:0] left_pend
);

  typedef enum logic [2:0] {
    PH_NS_LEFT = 3'd0,
    PH_NS_FWD  = 3'd1,
    PH_EW_LEFT = 3'd2,
    PH_EW_FWD  = 3'd3,
    PH_EMERG   = 3'd4,
    PH_INIT    = 3'd7
  } phase_e;

  typedef enum logic [1:0] {
    SUB_GRN = 2'd0,
    SUB_YEL = 2'd1,
    SUB_RED = 2'd2
  } sub_e;

  localparam logic [TMR_W-1:0] T_FWD  = TMR_W'(GREEN_FWD - 1);
  localparam logic [TMR_W-1:0] T_LEFT = TMR_W'(GREEN_LEFT - 1);
  localparam logic [TMR_W-1:0] T_YEL  = TMR_W'(YELLOW - 1);
  localparam logic [TMR_W-1:0] T_RED  = TMR_W'(ALL_RED - 1);
  localparam logic [TMR_W-1:0] T_ONE  = TMR_W'(1);

  phase_e           phase_q, phase_d;
  sub_e             sub_q, sub_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       pend_q, pend_d;
  logic             axis_q, axis_d;
  logic [3:0]       pend_clr;
  logic             tmr_zero;
  logic             fwd_match;
  phase_e           next_phase;

  // Phase that follows the current one after all-red, with empty left phases skipped
  function automatic phase_e after_red(input phase_e cur, input logic axis, input logic [3:0] pend);
    phase_e nxt;
    case (cur)
      PH_NS_LEFT: nxt = PH_NS_FWD;
      PH_NS_FWD:  nxt = PH_EW_LEFT;
      PH_EW_LEFT: nxt = PH_EW_FWD;
      PH_EMERG:   nxt = axis ? PH_NS_LEFT : PH_EW_LEFT;
      default:    nxt = PH_NS_LEFT;
    endcase
    if (nxt == PH_NS_LEFT && pend[3:2] == 2'b00) nxt = PH_NS_FWD;
    if (nxt == PH_EW_LEFT && pend[1:0] == 2'b00) nxt = PH_EW_FWD;
    return nxt;
  endfunction

  // State register: phase, sub-state, timer, demand latch and latched preempt axis
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_INIT;
      sub_q   <= SUB_RED;
      timer_q <= T_RED;
      pend_q  <= 4'b0000;
      axis_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sub_q   <= sub_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      axis_q  <= axis_d;
    end
  end

  // Next-state: sub-state timing, preempt handling, sequencing and demand latch
  always_comb begin
    phase_d    = phase_q;
    sub_d      = sub_q;
    timer_d    = timer_q;
    axis_d     = axis_q;
    pend_clr   = 4'b0000;
    tmr_zero   = (timer_q == '0);
    fwd_match  = (phase_q == PH_NS_FWD && !emerg_axis) || (phase_q == PH_EW_FWD && emerg_axis);
    next_phase = after_red(phase_q, axis_q, pend_q);
    case (sub_q)
      SUB_GRN: begin
        if (phase_q == PH_EMERG) begin
          if (!emerg_req) begin
            sub_d   = SUB_YEL;
            timer_d = T_YEL;
          end
        end else if (emerg_req && fwd_match) begin
          // Same axis already green: hand over without a yellow, timer frozen
          phase_d = PH_EMERG;
          axis_d  = emerg_axis;
        end else if (emerg_req || tmr_zero) begin
          sub_d   = SUB_YEL;
          timer_d = T_YEL;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      SUB_YEL: begin
        if (tmr_zero) begin
          sub_d   = SUB_RED;
          timer_d = T_RED;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      default: begin
        if (!tmr_zero) begin
          timer_d = timer_q - T_ONE;
        end else if (emerg_req) begin
          phase_d = PH_EMERG;
          sub_d   = SUB_GRN;
          axis_d  = emerg_axis;
        end else begin
          phase_d = next_phase;
          sub_d   = SUB_GRN;
          timer_d = (next_phase == PH_NS_LEFT || next_phase == PH_EW_LEFT) ? T_LEFT : T_FWD;
          if (next_phase == PH_NS_LEFT) pend_clr = 4'b1100;
          if (next_phase == PH_EW_LEFT) pend_clr = 4'b0011;
        end
      end
    endcase
    pend_d = (pend_q & ~pend_clr) | left_req;
  end

  // Lamp decode from registered state; only the active group is ever non-red
  always_comb begin
    logic [1:0] code;
    N_forward = 2'b00;
    N_left    = 2'b00;
    S_forward = 2'b00;
    S_left    = 2'b00;
    E_forward = 2'b00;
    E_left    = 2'b00;
    W_forward = 2'b00;
    W_left    = 2'b00;
    code      = (sub_q == SUB_GRN) ? 2'b10 : (sub_q == SUB_YEL) ? 2'b01 : 2'b00;
    case (phase_q)
      PH_NS_LEFT: begin N_left = code;    S_left = code;    end
      PH_NS_FWD:  begin N_forward = code; S_forward = code; end
      PH_EW_LEFT: begin E_left = code;    W_left = code;    end
      PH_EW_FWD:  begin E_forward = code; W_forward = code; end
      PH_EMERG: begin
        if (axis_q) begin
          E_forward = code;
          W_forward = code;
        end else begin
          N_forward = code;
          S_forward = code;
        end
      end
      default: ;
    endcase
  end

  assign phase        = phase_q;
  assign emerg_active = (phase_q == PH_EMERG) && (sub_q == SUB_GRN);
  assign left_pend    = pend_q;

endmodule
